// File: rtl/reset_seq_ctrl_pkg.sv
// Shared types and default constants for the reset sequencer.
// The optional statistics block is enabled with RST_SEQ_STATS_EN.
package reset_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    localparam int DEF_NUM_SRC     = 3;
    localparam int DEF_NUM_STAGES  = 2;
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_DATA_W      = 2;

    // Counter/index width; never collapses to zero bits for a count of one.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CNT_W = width_of(DEF_HOLD_CYCLES);

endpackage

// File: rtl/rst_seq_edge_det.sv
// Per-source masked rising-edge detect feeding a sticky pending vector.
// With RST_SEQ_STATS_EN the raw edge vector is exported for overrun detection.
module rst_seq_edge_det
    import reset_seq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req_src,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic               take,
    output logic [NUM_SRC-1:0] pending
`ifdef RST_SEQ_STATS_EN
    ,
    output logic [NUM_SRC-1:0] edges
`endif
);

    logic [NUM_SRC-1:0] live;
    logic [NUM_SRC-1:0] hist;
    logic [NUM_SRC-1:0] rise;

    assign live = req_src & ~src_mask;
    assign rise = live & ~hist;

`ifdef RST_SEQ_STATS_EN
    assign edges = rise;
`endif

    // An edge landing in the same cycle the vector is consumed is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist    <= '0;
            pending <= '0;
        end else begin
            hist    <= live;
            pending <= (take ? '0 : pending) | rise;
        end
    end

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: merges request sources into timed, ordered per-stage clears
// for the owned pipeline. Define RST_SEQ_STATS_EN to add seq_count/overrun.
//
// state   | meaning
// IDLE    | no sequence, all stages running
// ASSERT  | every stage held in clear for one hold period
// RELEASE | stages let go one per hold period, lowest index first
// DONE    | single ack cycle, then IDLE or a back-to-back ASSERT
module reset_seq_ctrl
    import reset_seq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    req_src,
    input  logic [NUM_SRC-1:0]    src_mask,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic [NUM_STAGES-1:0] stage_clr,
    output logic                  busy,
    output logic                  ack,
    output logic [NUM_SRC-1:0]    cause
`ifdef RST_SEQ_STATS_EN
    ,
    output logic [7:0]            seq_count,
    output logic                  overrun
`endif
);

    localparam int CNT_W = width_of(HOLD_CYCLES);
    localparam int IDX_W = width_of(NUM_STAGES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(HOLD_CYCLES - 1);

    seq_state_t            state;
    seq_state_t            state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [NUM_STAGES-1:0] clr_nxt;
    logic [NUM_SRC-1:0]    pending;
    logic                  take;
    logic                  tc;
    logic [DATA_W-1:0]     pipe [NUM_STAGES];

`ifdef RST_SEQ_STATS_EN
    logic [NUM_SRC-1:0]    edges;
`endif

    rst_seq_edge_det #(
        .NUM_SRC (NUM_SRC)
    ) u_edge_det (
        .clk      (clk),
        .rst      (rst),
        .req_src  (req_src),
        .src_mask (src_mask),
        .take     (take),
        .pending  (pending)
`ifdef RST_SEQ_STATS_EN
        ,
        .edges    (edges)
`endif
    );

    assign take = ((state == IDLE) || (state == DONE)) && (pending != '0);
    assign tc   = (cnt == CNT_TC);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        idx_nxt   = idx;
        clr_nxt   = stage_clr;
        case (state)
            IDLE: begin
                clr_nxt = '0;
                if (take) begin
                    state_nxt = ASSERT;
                    clr_nxt   = '1;
                end
            end
            ASSERT: begin
                clr_nxt = '1;
                // The end of the assert period is also stage 0's release point.
                if (tc) begin
                    state_nxt  = RELEASE;
                    clr_nxt[0] = 1'b0;
                    idx_nxt    = IDX_W'(1);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (stage_clr == '0) begin
                    state_nxt = DONE;
                end else if (tc) begin
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (k == int'(idx)) clr_nxt[k] = 1'b0;
                    end
                    idx_nxt = idx + 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                clr_nxt = '0;
                idx_nxt = '0;
                if (take) begin
                    state_nxt = ASSERT;
                    clr_nxt   = '1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                clr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ASSERT;
            cnt       <= '0;
            idx       <= '0;
            stage_clr <= '1;
            busy      <= 1'b1;
            ack       <= 1'b0;
            cause     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            stage_clr <= clr_nxt;
            busy      <= (state_nxt == ASSERT) || (state_nxt == RELEASE);
            ack       <= (state_nxt == DONE);
            if (take) cause <= pending;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= stage_clr[0] ? '0 : data_in;
            for (int k = 1; k < NUM_STAGES; k++) begin
                pipe[k] <= stage_clr[k] ? '0 : pipe[k-1];
            end
        end
    end

    assign data_out = pipe[NUM_STAGES-1];

`ifdef RST_SEQ_STATS_EN
    // A repeat edge on a source still waiting to be consumed is an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_count <= '0;
            overrun   <= 1'b0;
        end else begin
            if ((state == DONE) && (seq_count != 8'hFF)) seq_count <= seq_count + 8'd1;
            if (((edges & pending) != '0) && !take) overrun <= 1'b1;
        end
    end
`endif

endmodule
